bck_ctrl_stage_p: RTL
=====================

Name: bck_ctrl_stage_p

Overview:
- Parametrised successor to the backward-extension control stage of the SMEM pipeline.
- Sits between the backward-init stage and the occurrence-lookup stage.
- Advances the per-read backward loop counters (i, j) and the interval-list sizes once per accepted beat.
- Replaces the global stall with a valid/ready handshake plus a 2-entry skid buffer. Adds configurable widths, an opaque payload, bubble dropping and saturating finish/iteration counters.

Parameters:
POS_W, 7, width of i, j, sizes, addresses (read length up to 2^POS_W-1)
RNUM_W, 9, width of read_num
PAYLOAD_W, 352, opaque sideband carried unchanged (primary, pendingcurr x0/x1/x2/info, reserved token/mem info, last_one_read)
DROP_BUBBLE, 1, 1 = BUBBLE beats are consumed and not forwarded; 0 = forwarded with all fields zeroed
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
in_valid  in  1  upstream beat valid
in_ready  out  1  stage can accept (registered)
in_status  in  6  one-hot status (F_INIT/F_RUN/F_BREAK/BCK_INI/BCK_RUN/BCK_END, 0 = BUBBLE)
in_read_num  in  RNUM_W  read index
in_i, in_j  in  POS_W each  backward loop counters
in_new_size, in_new_last_size, in_fwd_size_n  in  POS_W each  interval list sizes
in_cur_wr_addr, in_cur_rd_addr, in_mem_wr_addr, in_min_intv  in  POS_W each  addresses / threshold
in_output_c  in  8  current base
in_iter_bnd  in  1  iteration boundary already reached
in_payload  in  PAYLOAD_W  opaque sideband
out_valid  out  1  beat valid
out_ready  in  1  downstream accept
out_* (same set as in_*)  out  same widths  updated fields
out_finish  out  1  read finished on this beat
finish_cnt, iter_cnt  out  CNT_W each  saturating statistics
clr_stats  in  1  synchronous clear of the counters

Behaviour:
- Reset (rst=0, asynchronous): all out_* = 0, out_status = 0, out_valid = 0, in_ready = 1, skid buffer empty, counters = 0. Reset asserted mid-transfer discards both buffered beats.
- Handshake:
  - Transfer when valid & ready on the same edge.
  - Output register latency 1 cycle. in_ready = !skid_full, registered.
  - When out_ready is low, out_* hold stable while out_valid is high. At most one further beat is captured into the skid entry.
  - No combinational path from out_ready to in_ready.
- Per accepted beat, combinational on the in_* fields:
  - BCK_RUN:
    - jb = (in_new_last_size != 0) & (in_j == in_new_last_size - 1), computed mod 2^POS_W.
    - out_j = jb ? 0 : in_j + 1, wrapping.
    - out_i = in_iter_bnd ? 0 : (jb & in_i > 0) ? in_i - 1 : in_i.
    - out_iter_bnd = in_iter_bnd | (jb & in_i == 0).
    - out_cur_wr_addr = jb ? in_fwd_size_n - 1 : in_cur_wr_addr.
    - out_new_last_size = jb ? in_new_size : in_new_last_size.
    - out_new_size = jb ? 0 : in_new_size.
    - out_finish = jb & (in_new_size == 0).
    - All other fields and the payload pass through.
  - BCK_INI: all fields pass through except out_output_c = 0, out_finish = 0, and the payload pending/last_one_read sub-fields cleared. The payload clear mask is a package constant.
  - Any other non-zero status, and BUBBLE: forwarded as BUBBLE with all fields 0 (payload 0). If DROP_BUBBLE=1 and in_status == 0, the beat is consumed with no output produced.
- Counters:
  - finish_cnt += 1 per output transfer with out_finish=1.
  - iter_cnt += 1 per output transfer where out_iter_bnd rises (in_iter_bnd = 0 and out_iter_bnd = 1).
  - Both saturate at all-ones.
  - clr_stats has priority over an increment in the same cycle.
- Boundaries:
  - in_new_last_size = 0 never yields jb, so j keeps incrementing and wraps.
  - in_fwd_size_n = 0 gives wr_addr = all-ones (legal, not flagged).
  - Simultaneous push into the skid entry and pop from the output register preserves order.

Decomposition:
- Package smem_pkg: status one-hot constants (F_INIT, F_RUN, F_BREAK, BCK_INI, BCK_RUN, BCK_END, BUBBLE), payload field offsets and the BCK_INI clear mask, and a packed beat-struct typedef parametrised via localparams.
- Sub-module bck_skid_buf: a generic 2-entry valid/ready skid buffer on the packed beat. The update logic stays in the top.

Test Plan:
- BCK_RUN i=3, j=4, new_last_size=5, new_size=2, fwd_size_n=10 -> i=2, j=0, new_last_size=2, new_size=0, wr_addr=9, finish=0, iter_bnd=0.
- BCK_RUN i=0, j=1, new_last_size=2, new_size=0, in_iter_bnd=0 -> j=0, iter_bnd=1, finish=1, finish_cnt=1, iter_cnt=1.
- BCK_INI with output_c=0x41 and a non-zero payload -> output_c=0; pending fields 0; other fields unchanged; 1-cycle latency.
- out_ready held low 5 cycles while sending 3 beats -> in_ready drops after 2 accepted beats, outputs are stable, and all 3 beats emerge in order once out_ready is released.
- BUBBLE and F_RUN beats with DROP_BUBBLE=1 -> the BUBBLE is absorbed with no out_valid; F_RUN emerges with status 0 and all fields zeroed.
- Reset pulsed with both buffer entries full -> out_valid=0 immediately (asynchronous), in_ready=1, counters 0; 100 finishes with CNT_W=4 -> finish_cnt saturates at 15.

Source files
------------

// File: rtl/smem_pkg.sv
// Shared SMEM pipeline definitions: one-hot stage status codes, payload sideband
// layout and the default-width beat record.
package smem_pkg;

  localparam int STATUS_W = 6;

  localparam logic [STATUS_W-1:0] BUBBLE  = 6'b000000;
  localparam logic [STATUS_W-1:0] F_INIT  = 6'b000001;
  localparam logic [STATUS_W-1:0] F_RUN   = 6'b000010;
  localparam logic [STATUS_W-1:0] F_BREAK = 6'b000100;
  localparam logic [STATUS_W-1:0] BCK_INI = 6'b001000;
  localparam logic [STATUS_W-1:0] BCK_RUN = 6'b010000;
  localparam logic [STATUS_W-1:0] BCK_END = 6'b100000;

  // Payload layout, LSB first: primary | pendingcurr x0 | x1 | x2 | info | reserved | last_one_read
  localparam int PL_W           = 352;
  localparam int PL_PRIMARY_LSB = 0;
  localparam int PL_PRIMARY_W   = 64;
  localparam int PL_X0_LSB      = 64;
  localparam int PL_X0_W        = 64;
  localparam int PL_X1_LSB      = 128;
  localparam int PL_X1_W        = 64;
  localparam int PL_X2_LSB      = 192;
  localparam int PL_X2_W        = 64;
  localparam int PL_INFO_LSB    = 256;
  localparam int PL_INFO_W      = 32;
  localparam int PL_RSV_LSB     = 288;
  localparam int PL_RSV_W       = 63;
  localparam int PL_LAST_LSB    = 351;

  function automatic logic [PL_W-1:0] span_mask(input int lsb, input int w);
    logic [PL_W-1:0] m;
    m = '0;
    for (int k = 0; k < PL_W; k++) begin
      if (k >= lsb && k < lsb + w) m[k] = 1'b1;
    end
    return m;
  endfunction

  // Sub-fields a fresh backward extension must not inherit from the previous read.
  localparam logic [PL_W-1:0] BCK_INI_CLR_MASK =
      span_mask(PL_X0_LSB, PL_X0_W) | span_mask(PL_X1_LSB, PL_X1_W) |
      span_mask(PL_X2_LSB, PL_X2_W) | span_mask(PL_INFO_LSB, PL_INFO_W) |
      span_mask(PL_LAST_LSB, 1);

  localparam int POS_W_DFLT  = 7;
  localparam int RNUM_W_DFLT = 9;

  typedef struct packed {
    logic [STATUS_W-1:0]    status;
    logic [RNUM_W_DFLT-1:0] read_num;
    logic [POS_W_DFLT-1:0]  i;
    logic [POS_W_DFLT-1:0]  j;
    logic [POS_W_DFLT-1:0]  new_size;
    logic [POS_W_DFLT-1:0]  new_last_size;
    logic [POS_W_DFLT-1:0]  fwd_size_n;
    logic [POS_W_DFLT-1:0]  cur_wr_addr;
    logic [POS_W_DFLT-1:0]  cur_rd_addr;
    logic [POS_W_DFLT-1:0]  mem_wr_addr;
    logic [POS_W_DFLT-1:0]  min_intv;
    logic [7:0]             output_c;
    logic                   iter_bnd;
    logic                   iter_rise;
    logic                   finish;
    logic [PL_W-1:0]        payload;
  } beat_t;

endpackage

// File: rtl/bck_skid_buf.sv
// Two-entry valid/ready buffer: an output register plus one skid entry. The
// upstream ready is a flop, so downstream ready never reaches it combinationally.
module bck_skid_buf
  import smem_pkg::*;
#(
  parameter int W = $bits(beat_t)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         out_v_q, out_v_d;
  logic         skid_v_q, skid_v_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         push;

  always_comb begin
    out_v_d     = out_v_q;
    out_data_d  = out_data_q;
    skid_v_d    = skid_v_q;
    skid_data_d = skid_data_q;
    push        = in_valid_i & ~skid_v_q;
    if (!out_v_q || out_ready_i) begin
      // Output slot frees up: the older skid beat always goes first.
      if (skid_v_q) begin
        out_v_d    = 1'b1;
        out_data_d = skid_data_q;
        skid_v_d   = push;
        if (push) skid_data_d = in_data_i;
      end else begin
        out_v_d = push;
        if (push) out_data_d = in_data_i;
      end
    end else if (push) begin
      skid_v_d    = 1'b1;
      skid_data_d = in_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v_q     <= 1'b0;
      skid_v_q    <= 1'b0;
      out_data_q  <= '0;
      skid_data_q <= '0;
    end else begin
      out_v_q     <= out_v_d;
      skid_v_q    <= skid_v_d;
      out_data_q  <= out_data_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign in_ready_o  = ~skid_v_q;
  assign out_valid_o = out_v_q;
  assign out_data_o  = out_data_q;

endmodule

// File: rtl/bck_ctrl_stage_p.sv
// Backward-extension control stage: advances the per-read (i, j) loop and the
// interval-list sizes for each accepted beat, behind a 2-entry skid buffer.
module bck_ctrl_stage_p
  import smem_pkg::*;
#(
  parameter int POS_W       = 7,
  parameter int RNUM_W      = 9,
  parameter int PAYLOAD_W   = 352,
  parameter int DROP_BUBBLE = 1,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [5:0]           in_status,
  input  logic [RNUM_W-1:0]    in_read_num,
  input  logic [POS_W-1:0]     in_i,
  input  logic [POS_W-1:0]     in_j,
  input  logic [POS_W-1:0]     in_new_size,
  input  logic [POS_W-1:0]     in_new_last_size,
  input  logic [POS_W-1:0]     in_fwd_size_n,
  input  logic [POS_W-1:0]     in_cur_wr_addr,
  input  logic [POS_W-1:0]     in_cur_rd_addr,
  input  logic [POS_W-1:0]     in_mem_wr_addr,
  input  logic [POS_W-1:0]     in_min_intv,
  input  logic [7:0]           in_output_c,
  input  logic                 in_iter_bnd,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [5:0]           out_status,
  output logic [RNUM_W-1:0]    out_read_num,
  output logic [POS_W-1:0]     out_i,
  output logic [POS_W-1:0]     out_j,
  output logic [POS_W-1:0]     out_new_size,
  output logic [POS_W-1:0]     out_new_last_size,
  output logic [POS_W-1:0]     out_fwd_size_n,
  output logic [POS_W-1:0]     out_cur_wr_addr,
  output logic [POS_W-1:0]     out_cur_rd_addr,
  output logic [POS_W-1:0]     out_mem_wr_addr,
  output logic [POS_W-1:0]     out_min_intv,
  output logic [7:0]           out_output_c,
  output logic                 out_iter_bnd,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic                 out_finish,
  output logic [CNT_W-1:0]     finish_cnt,
  output logic [CNT_W-1:0]     iter_cnt,
  input  logic                 clr_stats
);

  typedef struct packed {
    logic [STATUS_W-1:0]  status;
    logic [RNUM_W-1:0]    read_num;
    logic [POS_W-1:0]     i;
    logic [POS_W-1:0]     j;
    logic [POS_W-1:0]     new_size;
    logic [POS_W-1:0]     new_last_size;
    logic [POS_W-1:0]     fwd_size_n;
    logic [POS_W-1:0]     cur_wr_addr;
    logic [POS_W-1:0]     cur_rd_addr;
    logic [POS_W-1:0]     mem_wr_addr;
    logic [POS_W-1:0]     min_intv;
    logic [7:0]           output_c;
    logic                 iter_bnd;
    logic                 iter_rise;
    logic                 finish;
    logic [PAYLOAD_W-1:0] payload;
  } pbeat_t;

  localparam int BEAT_W = $bits(pbeat_t);
  localparam logic [PAYLOAD_W-1:0] CLR_MASK = PAYLOAD_W'(BCK_INI_CLR_MASK);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  pbeat_t           beat_d, beat_q;
  logic [POS_W-1:0] last_m1;
  logic             jb, is_drop, push_valid, xfer;
  logic [CNT_W-1:0] finish_cnt_q, finish_cnt_d, iter_cnt_q, iter_cnt_d;

  always_comb begin
    beat_d  = '0;
    last_m1 = in_new_last_size - 1'b1;
    jb      = 1'b0;
    if (in_status == BCK_RUN || in_status == BCK_INI) begin
      beat_d.status        = in_status;
      beat_d.read_num      = in_read_num;
      beat_d.i             = in_i;
      beat_d.j             = in_j;
      beat_d.new_size      = in_new_size;
      beat_d.new_last_size = in_new_last_size;
      beat_d.fwd_size_n    = in_fwd_size_n;
      beat_d.cur_wr_addr   = in_cur_wr_addr;
      beat_d.cur_rd_addr   = in_cur_rd_addr;
      beat_d.mem_wr_addr   = in_mem_wr_addr;
      beat_d.min_intv      = in_min_intv;
      beat_d.output_c      = in_output_c;
      beat_d.iter_bnd      = in_iter_bnd;
      beat_d.payload       = in_payload;
    end
    if (in_status == BCK_RUN) begin
      // jb: the inner j loop has walked the whole previous interval list.
      jb = (in_new_last_size != '0) && (in_j == last_m1);
      beat_d.j             = jb ? '0 : in_j + 1'b1;
      beat_d.i             = in_iter_bnd ? '0 :
                             (jb && in_i != '0) ? in_i - 1'b1 : in_i;
      beat_d.iter_bnd      = in_iter_bnd | (jb & (in_i == '0));
      beat_d.iter_rise     = ~in_iter_bnd & jb & (in_i == '0);
      beat_d.cur_wr_addr   = jb ? in_fwd_size_n - 1'b1 : in_cur_wr_addr;
      beat_d.new_last_size = jb ? in_new_size : in_new_last_size;
      beat_d.new_size      = jb ? '0 : in_new_size;
      beat_d.finish        = jb & (in_new_size == '0);
    end else if (in_status == BCK_INI) begin
      beat_d.output_c = '0;
      beat_d.payload  = in_payload & ~CLR_MASK;
    end
  end

  assign is_drop    = (DROP_BUBBLE != 0) && (in_status == BUBBLE);
  assign push_valid = in_valid & ~is_drop;

  bck_skid_buf #(
    .W(BEAT_W)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst),
    .in_valid_i (push_valid),
    .in_ready_o (in_ready),
    .in_data_i  (beat_d),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (beat_q)
  );

  assign xfer = out_valid & out_ready;

  always_comb begin
    finish_cnt_d = finish_cnt_q;
    iter_cnt_d   = iter_cnt_q;
    if (clr_stats) begin
      finish_cnt_d = '0;
      iter_cnt_d   = '0;
    end else if (xfer) begin
      if (beat_q.finish)    finish_cnt_d = sat_inc(finish_cnt_q);
      if (beat_q.iter_rise) iter_cnt_d   = sat_inc(iter_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      finish_cnt_q <= '0;
      iter_cnt_q   <= '0;
    end else begin
      finish_cnt_q <= finish_cnt_d;
      iter_cnt_q   <= iter_cnt_d;
    end
  end

  assign out_status        = beat_q.status;
  assign out_read_num      = beat_q.read_num;
  assign out_i             = beat_q.i;
  assign out_j             = beat_q.j;
  assign out_new_size      = beat_q.new_size;
  assign out_new_last_size = beat_q.new_last_size;
  assign out_fwd_size_n    = beat_q.fwd_size_n;
  assign out_cur_wr_addr   = beat_q.cur_wr_addr;
  assign out_cur_rd_addr   = beat_q.cur_rd_addr;
  assign out_mem_wr_addr   = beat_q.mem_wr_addr;
  assign out_min_intv      = beat_q.min_intv;
  assign out_output_c      = beat_q.output_c;
  assign out_iter_bnd      = beat_q.iter_bnd;
  assign out_payload       = beat_q.payload;
  assign out_finish        = beat_q.finish;
  assign finish_cnt        = finish_cnt_q;
  assign iter_cnt          = iter_cnt_q;

endmodule
